// File: rtl/adat_hold_stretcher.sv
// adat_hold_stretcher
//   Multi-channel pulse stretcher. Each channel detects ACTIVE_LEVEL on its
//   (optionally synchronised) input and forces that level on its output for
//   hold_len_r extra cycles. The hold length is a shared runtime register.
//
// Ports
//   clk_i          : clock, posedge
//   rst_ni         : asynchronous active-low reset
//   signal_i       : [CHANNELS] raw per-channel inputs
//   hold_len_i     : [HB] new hold length (clamped to HOLD_MAX)
//   hold_len_we_i  : write strobe for hold_len_i
//   signal_o       : [CHANNELS] stretched outputs
//   holding_o      : [CHANNELS] output active due to detection or hold
//   any_holding_o  : OR of holding_o (registers only)

module adat_hold_chan #(
    parameter int HB           = 8,
    parameter bit ACTIVE_LEVEL = 1'b0,
    parameter bit RETRIGGER    = 1'b0,
    parameter int SYNC_STAGES  = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          signal_i,
    input  logic [HB-1:0] hold_len_i,
    output logic          signal_o,
    output logic          holding_o
);
    typedef enum logic {ST_IDLE, ST_HOLD} state_e;

    logic          s;
    logic          det;
    state_e        state;
    logic [HB-1:0] cnt_q, cnt_d;
    logic          sig_q, sig_d;
    logic          hold_q, hold_d;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_q <= {SYNC_STAGES{~ACTIVE_LEVEL}};
                end else begin
                    sync_q[0] <= signal_i;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s = signal_i;
        end
    endgenerate

    assign det = (s == ACTIVE_LEVEL);

    // The counter itself is the state: zero means idle.
    assign state = (cnt_q == '0) ? ST_IDLE : ST_HOLD;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            sig_q  <= ~ACTIVE_LEVEL;
            hold_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sig_q  <= sig_d;
            hold_q <= hold_d;
        end
    end

    always_comb begin
        cnt_d  = '0;
        sig_d  = ~ACTIVE_LEVEL;
        hold_d = 1'b0;
        case (state)
            ST_IDLE: begin
                sig_d = s;
                if (det) begin
                    cnt_d  = hold_len_i;
                    // zero length is pure pass-through, never "holding"
                    hold_d = (hold_len_i != '0);
                end
            end
            ST_HOLD: begin
                sig_d  = ACTIVE_LEVEL;
                hold_d = 1'b1;
                cnt_d  = (RETRIGGER && det) ? hold_len_i : (cnt_q - HB'(1));
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign signal_o  = sig_q;
    assign holding_o = hold_q;
endmodule

module adat_hold_stretcher #(
    parameter int  CHANNELS     = 4,
    parameter int  HOLD_MAX     = 255,
    parameter int  HOLD_RESET   = 1,
    parameter bit  ACTIVE_LEVEL = 1'b0,
    parameter bit  RETRIGGER    = 1'b0,
    parameter int  SYNC_STAGES  = 0,
    localparam int HB           = $clog2(HOLD_MAX + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CHANNELS-1:0] signal_i,
    input  logic [HB-1:0]       hold_len_i,
    input  logic                hold_len_we_i,
    output logic [CHANNELS-1:0] signal_o,
    output logic [CHANNELS-1:0] holding_o,
    output logic                any_holding_o
);
    logic [HB-1:0] hold_len_r;

    // Channels read the registered value, so a write on the same edge as a
    // detection still loads the old length.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_len_r <= HB'(HOLD_RESET);
        end else if (hold_len_we_i) begin
            hold_len_r <= (hold_len_i > HB'(HOLD_MAX)) ? HB'(HOLD_MAX) : hold_len_i;
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            adat_hold_chan #(
                .HB           (HB),
                .ACTIVE_LEVEL (ACTIVE_LEVEL),
                .RETRIGGER    (RETRIGGER),
                .SYNC_STAGES  (SYNC_STAGES)
            ) u_chan (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .signal_i   (signal_i[c]),
                .hold_len_i (hold_len_r),
                .signal_o   (signal_o[c]),
                .holding_o  (holding_o[c])
            );
        end
    endgenerate

    assign any_holding_o = |holding_o;
endmodule

// File: tb/tb_adat_hold_stretcher.sv
// Directed bench for adat_hold_stretcher. Three configurations share clock
// and reset:
//   A: 4 ch, active-low, no retrigger, no sync, HOLD_RESET=1 (vector table)
//   B: 4 ch, active-low, retrigger, 2 sync stages, HOLD_MAX=200 (clamp)
//   C: 8 ch, active-high, no retrigger, no sync
// Inputs are driven 1 time unit after posedge, outputs sampled there too.

module tb_adat_hold_stretcher;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // DUT A
    logic [3:0] a_sig = 4'hF, a_out, a_hold;
    logic [7:0] a_len = '0;
    logic       a_we = 1'b0, a_any;
    // DUT B
    logic [3:0] b_sig = 4'hF, b_out, b_hold;
    logic [7:0] b_len = '0;
    logic       b_we = 1'b0, b_any;
    // DUT C
    logic [7:0] c_sig = 8'h00, c_out, c_hold;
    logic [7:0] c_len = '0;
    logic       c_we = 1'b0, c_any;

    adat_hold_stretcher #(.CHANNELS(4), .HOLD_MAX(255), .HOLD_RESET(1),
        .ACTIVE_LEVEL(1'b0), .RETRIGGER(1'b0), .SYNC_STAGES(0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .signal_i(a_sig), .hold_len_i(a_len),
        .hold_len_we_i(a_we), .signal_o(a_out), .holding_o(a_hold),
        .any_holding_o(a_any));

    adat_hold_stretcher #(.CHANNELS(4), .HOLD_MAX(200), .HOLD_RESET(1),
        .ACTIVE_LEVEL(1'b0), .RETRIGGER(1'b1), .SYNC_STAGES(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .signal_i(b_sig), .hold_len_i(b_len),
        .hold_len_we_i(b_we), .signal_o(b_out), .holding_o(b_hold),
        .any_holding_o(b_any));

    adat_hold_stretcher #(.CHANNELS(8), .HOLD_MAX(255), .HOLD_RESET(1),
        .ACTIVE_LEVEL(1'b1), .RETRIGGER(1'b0), .SYNC_STAGES(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .signal_i(c_sig), .hold_len_i(c_len),
        .hold_len_we_i(c_we), .signal_o(c_out), .holding_o(c_hold),
        .any_holding_o(c_any));

    typedef struct {
        logic [3:0] sig;
        logic [7:0] len;
        logic       we;
        logic [3:0] esig;
        logic [3:0] ehold;
        logic       eany;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic [3:0] sig, input logic [7:0] len, input logic we,
                       input logic [3:0] esig, input logic [3:0] ehold, input logic eany);
        vec_t v;
        v.sig = sig; v.len = len; v.we = we;
        v.esig = esig; v.ehold = ehold; v.eany = eany;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, hi, first, other_bad;
        logic [3:0] hist[40];

        // ---------------- vector table for DUT A ----------------
        add(4'hF, 8'd0, 1'b0, 4'hF, 4'h0, 1'b0);
        // reset length 1: 1-cycle low -> 2 cycles low
        add(4'hE, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hF, 4'h0, 1'b0);
        // length 3: 1-cycle low on ch0 -> 4 cycles low
        add(4'hF, 8'd3, 1'b1, 4'hF, 4'h0, 1'b0);
        add(4'hE, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        repeat (3) add(4'hF, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hF, 4'h0, 1'b0);
        // staggered channels: ch1/ch3, then ch0 one cycle later
        add(4'h5, 8'd0, 1'b0, 4'h5, 4'hA, 1'b1);
        add(4'hE, 8'd0, 1'b0, 4'h4, 4'hB, 1'b1);
        repeat (2) add(4'hF, 8'd0, 1'b0, 4'h4, 4'hB, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hF, 4'h0, 1'b0);
        // continuous active input -> continuous active output
        repeat (6) add(4'hE, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        repeat (2) add(4'hF, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hF, 4'h0, 1'b0);
        // write on detection edge: old length 3 used, then new length 1
        add(4'hE, 8'd1, 1'b1, 4'hE, 4'h1, 1'b1);
        repeat (3) add(4'hF, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hF, 4'h0, 1'b0);
        add(4'hE, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hF, 4'h0, 1'b0);
        // length 0: pass-through, never holding
        add(4'hF, 8'd0, 1'b1, 4'hF, 4'h0, 1'b0);
        add(4'hA, 8'd0, 1'b0, 4'hA, 4'h0, 1'b0);
        add(4'h5, 8'd0, 1'b0, 4'h5, 4'h0, 1'b0);
        add(4'hF, 8'd0, 1'b0, 4'hF, 4'h0, 1'b0);
        // length 8, rewrite to 2 mid-hold: 9 cycles, then next one 3
        add(4'hF, 8'd8, 1'b1, 4'hF, 4'h0, 1'b0);
        add(4'hE, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd2, 1'b1, 4'hE, 4'h1, 1'b1);
        repeat (7) add(4'hF, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hF, 4'h0, 1'b0);
        add(4'hE, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        repeat (2) add(4'hF, 8'd0, 1'b0, 4'hE, 4'h1, 1'b1);
        add(4'hF, 8'd0, 1'b0, 4'hF, 4'h0, 1'b0);

        // ---------------- reset state ----------------
        #1 rst_n = 1'b0;
        #1;
        chk("reset A sig", a_out, 4'hF);
        chk("reset A hold", a_hold, 4'h0);
        chk("reset A any", a_any, 1'b0);
        chk("reset B sig", b_out, 4'hF);
        chk("reset C sig", c_out, 8'h00);
        chk("reset C hold", c_hold, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- DUT A table ----------------
        foreach (vecs[i]) begin
            a_sig = vecs[i].sig; a_len = vecs[i].len; a_we = vecs[i].we;
            tick();
            chk($sformatf("A row%0d sig", i), a_out, vecs[i].esig);
            chk($sformatf("A row%0d hold", i), a_hold, vecs[i].ehold);
            chk($sformatf("A row%0d any", i), a_any, vecs[i].eany);
        end
        a_sig = 4'hF; a_we = 1'b0;

        // ---------------- DUT B: retrigger, latency 2 sync stages ----------------
        b_len = 8'd5; b_we = 1'b1; tick(); b_we = 1'b0;
        repeat (4) tick();
        lo = 0; hi = 0; first = -1; other_bad = 0;
        for (int t = 0; t < 20; t++) begin
            b_sig = (t == 0 || t == 3) ? 4'hE : 4'hF;
            tick();
            if (b_out[0] == 1'b0) begin lo++; if (first < 0) first = t; end
            if (b_hold[0]) hi++;
            if (b_out[3:1] != 3'b111 || b_hold[3:1] != 3'b000) other_bad++;
        end
        chk("B retrig low cycles", lo, 9);
        chk("B retrig hold cycles", hi, 9);
        chk("B retrig first low", first, 2);
        chk("B retrig other ch", other_bad, 0);

        // clamp: 250 -> 200, single detection gives 201 active cycles
        b_len = 8'd250; b_we = 1'b1; tick(); b_we = 1'b0;
        repeat (3) tick();
        lo = 0; hi = 0; first = -1;
        for (int t = 0; t < 230; t++) begin
            b_sig = (t == 0) ? 4'hE : 4'hF;
            tick();
            if (b_out[0] == 1'b0) begin lo++; if (first < 0) first = t; end
            if (b_hold[0]) hi++;
        end
        chk("B clamp low cycles", lo, 201);
        chk("B clamp hold cycles", hi, 201);
        chk("B clamp first low", first, 2);

        // pass-through: output is input two samples later (one edge per stage)
        b_len = 8'd0; b_we = 1'b1; tick(); b_we = 1'b0;
        for (int t = 0; t < 40; t++) begin
            hist[t] = 4'($urandom);
            b_sig = hist[t];
            tick();
            if (t >= 2) chk($sformatf("B pass t%0d", t), b_out, hist[t-2]);
            chk($sformatf("B pass hold t%0d", t), b_hold, 4'h0);
        end
        b_sig = 4'hF;

        // ---------------- DUT C: active-high, concurrent detection + write ----------------
        c_len = 8'd4; c_we = 1'b1; tick(); c_we = 1'b0; tick();
        for (int t = 0; t < 8; t++) begin
            c_sig = (t == 0) ? 8'h84 : 8'h00;
            c_we  = (t == 0);
            c_len = 8'd1;
            tick();
            chk($sformatf("C conc sig t%0d", t), c_out, (t < 5) ? 8'h84 : 8'h00);
            chk($sformatf("C conc hold t%0d", t), c_hold, (t < 5) ? 8'h84 : 8'h00);
            chk($sformatf("C conc any t%0d", t), c_any, (t < 5) ? 1'b1 : 1'b0);
        end
        c_we = 1'b0;
        for (int t = 0; t < 4; t++) begin
            c_sig = (t == 0) ? 8'h04 : 8'h00;
            tick();
            chk($sformatf("C newlen sig t%0d", t), c_out, (t < 2) ? 8'h04 : 8'h00);
        end

        // ---------------- asynchronous reset mid-hold ----------------
        a_len = 8'd6; a_we = 1'b1; tick(); a_we = 1'b0;
        a_sig = 4'hE; tick();
        a_sig = 4'hF; tick(); tick();
        chk("A pre-reset holding", a_hold, 4'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("A midreset sig", a_out, 4'hF);
        chk("A midreset hold", a_hold, 4'h0);
        chk("A midreset any", a_any, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // hold length is back to 1: 1-cycle low -> 2 cycles low
        a_sig = 4'hE; tick();
        chk("A postreset c0 sig", a_out, 4'hE);
        chk("A postreset c0 hold", a_hold, 4'h1);
        a_sig = 4'hF; tick();
        chk("A postreset c1 sig", a_out, 4'hE);
        tick();
        chk("A postreset c2 sig", a_out, 4'hF);
        chk("A postreset c2 any", a_any, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
